// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared op codes, latency defaults and helpers for the MIPS
//                multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // MDOp encodings driven by the controller; 7 is unused and acts as a no-op.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // Default latencies, counted from the accepting edge to the HI/LO update.
    localparam int C_MD_MULT_CYCLES = 5;
    localparam int C_MD_DIV_CYCLES  = 10;

    // Counter width: supports latencies up to 15.
    localparam int C_CNT_W = 4;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_core.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_core
//  Description : Combinational multiply/divide datapath. Produces {hi,lo} for
//                the latched op and flags a zero divisor on divide ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_core
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes, then restores signs: quotient
    // truncates toward zero, remainder follows the dividend. The magnitude of
    // 0x80000000 is representable unsigned, so MIN/-1 wraps to 0x80000000.
    assign w_a_neg   = (op == MD_DIV) && a[31];
    assign w_b_neg   = (op == MD_DIV) && b[31];
    assign w_a_mag   = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag   = w_b_neg ? (32'd0 - b) : b;
    // Substitute divisor for B==0 keeps the arithmetic defined; result is discarded.
    assign w_divisor = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag   = w_a_mag / w_divisor;
    assign w_r_mag   = w_a_mag % w_divisor;
    assign w_quot    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem     = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    assign div_by_zero = is_div_op(op) && (b == 32'd0);

    // Select the {hi,lo} pair for the latched op.
    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:          result = w_prod_s;
            MD_MULTU:         result = w_prod_u;
            MD_DIV, MD_DIVU:  result = {w_rem, w_quot};
            default:          result = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : MIPS multiply/divide unit. Holds HI/LO, latches operands on
//                an accepted MULT/DIV, counts a fixed latency and raises Busy
//                while the operation is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = C_MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = C_MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDOp,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    localparam logic [C_CNT_W-1:0] C_MULT_N = C_CNT_W'(MULT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_DIV_N  = C_CNT_W'(DIV_CYCLES);

    logic [C_CNT_W-1:0] r_count;
    logic [2:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [63:0]        w_result;
    logic               w_div_by_zero;

    // Result math sees only the latched operands, so bus changes while busy are harmless.
    mdu_core u_core (
        .op          (r_op),
        .a           (r_a),
        .b           (r_b),
        .result      (w_result),
        .div_by_zero (w_div_by_zero)
    );

    // Control, operand latches and architectural HI/LO. A running operation
    // has priority over Start, so Start while busy is simply dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_op    <= MD_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
            // Final edge of the operation; a zero divisor leaves HI/LO untouched.
            if ((r_count == C_CNT_W'(1)) && !w_div_by_zero) begin
                r_hi <= w_result[63:32];
                r_lo <= w_result[31:0];
            end
        end else if (Start) begin
            case (MDOp)
                MD_MTHI: r_hi <= A;
                MD_MTLO: r_lo <= A;
                MD_MULT, MD_MULTU: begin
                    r_op    <= MDOp;
                    r_a     <= A;
                    r_b     <= B;
                    r_count <= C_MULT_N;
                end
                MD_DIV, MD_DIVU: begin
                    r_op    <= MDOp;
                    r_a     <= A;
                    r_b     <= B;
                    r_count <= C_DIV_N;
                end
                default: ;
            endcase
        end
    end

    assign Busy = (r_count != '0);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire
